// File: rtl/atmega_spi_pkg.sv
// ---------------------------------------------------------------------------
// atmega_spi_pkg
// Shared definitions for the SPI burst controller: the FSM state encoding
// and the SPSR bit that flags transfer completion (SPIF).
// ---------------------------------------------------------------------------
package atmega_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_WRITE,
    ST_POLL,
    ST_READ,
    ST_NEXT,
    ST_CS_HOLD
  } state_e;

  // SPSR bit 7 is set by the SPI core when a byte has been shifted.
  localparam int SPIF_BIT = 7;

endpackage

// File: rtl/atmega_spi_burst_fifo.sv
// ---------------------------------------------------------------------------
// atmega_spi_burst_fifo
// Synchronous receive FIFO with a combinational head.
//   clk, rst        clock, synchronous active-high reset
//   push_i/wdata_i  write strobe and data (ignored when full)
//   pop_i           removes the head (ignored when empty)
//   rdata_o         current head, valid whenever empty_o = 0
//   full_o/empty_o  occupancy flags
// DEPTH must be a power of two (>= 2), so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module atmega_spi_burst_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // Push and pop together leave the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, and a reset-free array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/atmega_spi_burst_ctrl.sv
// ---------------------------------------------------------------------------
// atmega_spi_burst_ctrl
// Streams framed bytes through an ATmega-style SPI core over its register
// bus: write SPDR, poll SPSR.SPIF, read SPDR, push the result to an RX FIFO.
// cs_n stays low across a frame with programmable setup/hold margins.
//   tx_data/tx_last/tx_valid/tx_ready   byte stream in (tx_last ends frame)
//   rx_data/rx_valid/rx_ready           received bytes out (FIFO head)
//   cs_n                                slave select, active-low
//   busy                                FSM not idle; owns the register bus
//   spi_addr/spi_wr/spi_rd/spi_wdata    register bus to the SPI core
//   spi_rdata                           combinational read data from core
// ---------------------------------------------------------------------------
module atmega_spi_burst_ctrl
  import atmega_spi_pkg::*;
#(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter int SPSR_ADDR         = 'h21,
  parameter int SPDR_ADDR         = 'h22,
  parameter int RX_FIFO_DEPTH     = 16,
  parameter int CS_SETUP_CLKS     = 2,
  parameter int CS_HOLD_CLKS      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_last,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic                         cs_n,
  output logic                         busy,
  output logic [BUS_ADDR_DATA_LEN-1:0] spi_addr,
  output logic                         spi_wr,
  output logic                         spi_rd,
  output logic [7:0]                   spi_wdata,
  input  logic [7:0]                   spi_rdata
);

  localparam logic [BUS_ADDR_DATA_LEN-1:0] SPSR_A = BUS_ADDR_DATA_LEN'(SPSR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] SPDR_A = BUS_ADDR_DATA_LEN'(SPDR_ADDR);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP_CLKS - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD_CLKS - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic       cs_n_q, cs_n_d;
  logic       fifo_push, fifo_full, fifo_empty;

  atmega_spi_burst_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (spi_rdata),
    .pop_i   (rx_ready),
    .rdata_o (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
  assign busy     = (state_q != ST_IDLE);
  // cs_n comes straight from a flop so the slave select never glitches.
  assign cs_n     = cs_n_q;

  // NOTE: state registers use non-blocking assignments; the always_comb
  // below uses blocking ones, with every output defaulted first so no
  // latches are inferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      cs_n_q  <= cs_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    last_d    = last_q;
    cs_n_d    = cs_n_q;
    tx_ready  = 1'b0;
    spi_wr    = 1'b0;
    spi_rd    = 1'b0;
    spi_addr  = '0;
    spi_wdata = '0;
    fifo_push = 1'b0;

    // Bus strobes, tx_ready and the FIFO push are suppressed while rst is
    // held, so nothing leaks out before the synchronous reset is taken.
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          tx_ready = !fifo_full;
          if (tx_valid && tx_ready) begin
            byte_d  = tx_data;
            last_d  = tx_last;
            cs_n_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_d   = '0;
            state_d = ST_WRITE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_WRITE: begin
          spi_wr    = 1'b1;
          spi_addr  = SPDR_A;
          spi_wdata = byte_q;
          state_d   = ST_POLL;
        end
        ST_POLL: begin
          // Reading SPSR with SPIF set arms the core's SPIF clear.
          spi_rd   = 1'b1;
          spi_addr = SPSR_A;
          if (spi_rdata[SPIF_BIT]) state_d = ST_READ;
        end
        ST_READ: begin
          // A free FIFO slot was guaranteed when this byte was accepted.
          spi_rd    = 1'b1;
          spi_addr  = SPDR_A;
          fifo_push = 1'b1;
          state_d   = ST_NEXT;
        end
        ST_NEXT: begin
          if (last_q) begin
            cnt_d   = '0;
            state_d = ST_CS_HOLD;
          end else begin
            tx_ready = !fifo_full;
            if (tx_valid && tx_ready) begin
              byte_d  = tx_data;
              last_d  = tx_last;
              state_d = ST_WRITE;
            end
          end
        end
        ST_CS_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            cs_n_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atmega_spi_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_atmega_spi_burst_ctrl
// Directed bench with a behavioural loopback SPI core (MISO = MOSI). Each
// byte takes xfer_len clocks in the core (32 for SPCR=0x50, fosc/4; 1024
// for SPR=11, fosc/128); with that model a byte spends xfer_len+1 cycles in
// POLL, so one byte keeps cs_n low for 2 + (1+33+1+1) + 2 = 40 cycles.
// ---------------------------------------------------------------------------
module tb_atmega_spi_burst_ctrl;

  localparam logic [7:0] SPSR_A = 8'h21;
  localparam logic [7:0] SPDR_A = 8'h22;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_ready_man = 1'b0;
  logic       pop_on_read = 1'b0;
  logic       cs_n, busy;
  logic [7:0] spi_addr;
  logic       spi_wr, spi_rd;
  logic [7:0] spi_wdata, spi_rdata;

  always #5 clk = ~clk;

  // Optional pop exactly during READ cycles, for same-cycle push/pop.
  assign rx_ready = rx_ready_man | (pop_on_read & spi_rd & (spi_addr == SPDR_A));

  atmega_spi_burst_ctrl #(
    .BUS_ADDR_DATA_LEN (8),
    .SPSR_ADDR         ('h21),
    .SPDR_ADDR         ('h22),
    .RX_FIFO_DEPTH     (2),
    .CS_SETUP_CLKS     (2),
    .CS_HOLD_CLKS      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .cs_n      (cs_n),
    .busy      (busy),
    .spi_addr  (spi_addr),
    .spi_wr    (spi_wr),
    .spi_rd    (spi_rd),
    .spi_wdata (spi_wdata),
    .spi_rdata (spi_rdata)
  );

  // ---------------- loopback SPI core model ----------------
  int         xfer_len = 32;
  int         bcnt;
  logic       spif;
  logic [7:0] shreg, dreg;

  always @(posedge clk) begin
    if (rst) begin
      spif <= 1'b0; bcnt <= 0; shreg <= '0; dreg <= '0;
    end else begin
      if (spi_wr && spi_addr == SPDR_A) begin
        shreg <= spi_wdata;
        bcnt  <= xfer_len;
      end else if (bcnt == 1) begin
        spif <= 1'b1;
        dreg <= shreg;
        bcnt <= 0;
      end else if (bcnt > 1) begin
        bcnt <= bcnt - 1;
      end
      if (spi_rd && spi_addr == SPDR_A) spif <= 1'b0;
    end
  end

  assign spi_rdata = (spi_rd && spi_addr == SPSR_A) ? {spif, 7'b0} :
                     (spi_rd && spi_addr == SPDR_A) ? dreg : 8'h00;

  // ---------------- monitor (samples on negedge) ----------------
  int         cs_low, pre_wr, wr_cnt, rd_cnt, poll_cnt, rise_cnt, dual_cnt;
  int         overlap = 0;
  logic       cs_prev = 1'b1;
  logic [7:0] rx_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (!cs_n) cs_low++;
      if (!cs_n && wr_cnt == 0 && !spi_wr) pre_wr++;
      if (spi_wr && spi_addr == SPDR_A) wr_cnt++;
      if (spi_rd && spi_addr == SPDR_A) rd_cnt++;
      if (spi_rd && spi_addr == SPSR_A) poll_cnt++;
      if (spi_wr && spi_rd) overlap++;
      if (cs_n && !cs_prev) rise_cnt++;
      cs_prev = cs_n;
      if (rx_valid && rx_ready) begin
        rx_q.push_back(rx_data);
        if (spi_rd && spi_addr == SPDR_A) dual_cnt++;
      end
    end
  end

  // ---------------- checking ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cs_low = 0; pre_wr = 0; wr_cnt = 0; rd_cnt = 0;
    poll_cnt = 0; rise_cnt = 0; dual_cnt = 0;
    rx_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    int n = 0;
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!tx_ready && n < 5000);
    check("tx_accept", {31'b0, tx_ready}, 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check(tag, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp [$]);
    check({tag, "_count"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_rx%0d", tag, i), (i < rx_q.size()) ? {24'b0, rx_q[i]} : 32'hdead, {24'b0, exp[i]});
  endtask

  initial begin
    clear_stats();

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_ready", {31'b0, tx_ready}, 0);
    check("rst_cs_n",     {31'b0, cs_n},     1);
    check("rst_busy",     {31'b0, busy},     0);
    check("rst_strobes",  {30'b0, spi_wr, spi_rd}, 0);
    check("rst_addr",     {24'b0, spi_addr}, 0);
    check("rst_wdata",    {24'b0, spi_wdata}, 0);
    check("rst_rx_valid", {31'b0, rx_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rx_ready_man = 1'b1;
    @(negedge clk);
    check("idle_tx_ready", {31'b0, tx_ready}, 1);
    @(posedge clk); #1;

    // ---- single byte 0xA5 ----
    clear_stats();
    push_byte(8'hA5, 1'b1);
    wait_idle("single_done");
    check("single_wr", wr_cnt, 1);
    check("single_cs_low", cs_low, 40);
    check("single_setup", pre_wr, 2);
    check("single_cs_rise", rise_cnt, 1);
    check_rx("single", '{8'hA5});

    // ---- frame 01 02 03 ----
    clear_stats();
    push_byte(8'h01, 1'b0);
    push_byte(8'h02, 1'b0);
    push_byte(8'h03, 1'b1);
    wait_idle("frame_done");
    check("frame_wr", wr_cnt, 3);
    check("frame_cs_low", cs_low, 112);
    check("frame_cs_rise", rise_cnt, 1);
    check_rx("frame", '{8'h01, 8'h02, 8'h03});

    // ---- back-pressure: depth 2, rx_ready low, 4-byte frame ----
    clear_stats();
    rx_ready_man = 1'b0;
    fork
      begin
        push_byte(8'hAA, 1'b0);
        push_byte(8'hBB, 1'b0);
        push_byte(8'hCC, 1'b0);
        push_byte(8'hDD, 1'b1);
      end
      begin
        repeat (150) @(negedge clk);
        check("stall_tx_ready", {31'b0, tx_ready}, 0);
        check("stall_cs_n",     {31'b0, cs_n},     0);
        check("stall_busy",     {31'b0, busy},     1);
        check("stall_rx_data",  {24'b0, rx_data},  32'hAA);
        check("stall_wr",       wr_cnt, 2);
        @(posedge clk); #1;
        rx_ready_man = 1'b1;
      end
    join
    wait_idle("stall_done");
    check("stall_wr_total", wr_cnt, 4);
    check("stall_cs_rise", rise_cnt, 1);
    check_rx("stall", '{8'hAA, 8'hBB, 8'hCC, 8'hDD});

    // ---- same-cycle push/pop at one entry (depth-1), pointers wrap ----
    clear_stats();
    rx_ready_man = 1'b0;
    pop_on_read  = 1'b1;
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0);
    push_byte(8'h44, 1'b1);
    wait_idle("wrap_done");
    pop_on_read = 1'b0;
    check("wrap_dual", dual_cnt, 3);
    check("wrap_valid", {31'b0, rx_valid}, 1);
    check("wrap_head", {24'b0, rx_data}, 32'h44);
    rx_ready_man = 1'b1;
    @(posedge clk); #1;
    rx_ready_man = 1'b0;
    @(negedge clk);
    check("wrap_empty", {31'b0, rx_valid}, 0);
    check_rx("wrap", '{8'h11, 8'h22, 8'h33, 8'h44});
    @(posedge clk); #1;
    rx_ready_man = 1'b1;

    // ---- slow prescaler (SPR=11, fosc/128 -> 1024 clk/byte) ----
    clear_stats();
    xfer_len = 1024;
    push_byte(8'h96, 1'b1);
    wait_idle("slow_done");
    xfer_len = 32;
    check("slow_polls", poll_cnt, 1025);
    check("slow_reads", rd_cnt, 1);
    check("slow_wr", wr_cnt, 1);
    check_rx("slow", '{8'h96});

    // ---- reset while polling ----
    clear_stats();
    push_byte(8'h5A, 1'b1);
    begin
      int n = 0;
      while (!(spi_rd && spi_addr == SPSR_A) && n < 200) begin @(negedge clk); n++; end
    end
    check("rst_poll_seen", {31'b0, spi_rd}, 1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstp_tx_ready", {31'b0, tx_ready}, 0);
    check("rstp_spi_rd",   {31'b0, spi_rd},   0);
    check("rstp_addr",     {24'b0, spi_addr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstp_cs_n",     {31'b0, cs_n},     1);
    check("rstp_busy",     {31'b0, busy},     0);
    check("rstp_rx_valid", {31'b0, rx_valid}, 0);
    check("rstp_no_push",  rx_q.size(), 0);
    @(posedge clk); #1;

    clear_stats();
    push_byte(8'h3C, 1'b1);
    wait_idle("after_rst_done");
    check("after_rst_wr", wr_cnt, 1);
    check("after_rst_cs_low", cs_low, 40);
    check_rx("after_rst", '{8'h3C});

    check("no_wr_rd_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/atmega_spi_burst_ctrl.md
ATMEGA_SPI_BURST_CTRL -- requirements
Module: atmega_spi_burst_ctrl

Interface
REQ-001 Parameter BUS_ADDR_DATA_LEN, default 8: width of the SPI register address bus.
REQ-002 Parameter SPSR_ADDR, default 'h21: SPI status register address.
REQ-003 Parameter SPDR_ADDR, default 'h22: SPI data register address.
REQ-004 Parameter RX_FIFO_DEPTH, default 16: receive FIFO entries; power of 2, minimum 2.
REQ-005 Parameter CS_SETUP_CLKS, default 2: clk cycles from cs_n falling to the first SPDR write; range 1..255.
REQ-006 Parameter CS_HOLD_CLKS, default 2: clk cycles after the last byte completes before cs_n rises; range 1..255.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 tx_data  in  8  byte to transmit.
REQ-010 tx_last  in  1  marks tx_data as the final byte of a frame.
REQ-011 tx_valid  in  1  tx_data/tx_last valid.
REQ-012 tx_ready  out  1  byte accepted when tx_valid&tx_ready.
REQ-013 rx_data  out  8  received byte (RX FIFO head).
REQ-014 rx_valid  out  1  RX FIFO not empty.
REQ-015 rx_ready  in  1  pops the head when rx_valid&rx_ready.
REQ-016 cs_n  out  1  slave select, active-low.
REQ-017 busy  out  1  high whenever the FSM is not IDLE; the integrator gives this block the SPI register bus while busy=1.
REQ-018 spi_addr  out  BUS_ADDR_DATA_LEN  address to the SPI core.
REQ-019 spi_wr  out  1  SPI register write strobe.
REQ-020 spi_rd  out  1  SPI register read strobe.
REQ-021 spi_wdata  out  8  write data to the SPI core bus_in.
REQ-022 spi_rdata  in  8  combinational read data from the SPI core bus_out.

Function
REQ-023 The SPI core is configured beforehand (SPCR: enabled, master); completion is detected by polling SPSR bit 7 (SPIF), so the SPI core's interrupt enable is not required.
REQ-024 FSM states: IDLE, CS_SETUP, WRITE, POLL, READ, NEXT, CS_HOLD.
REQ-025 IDLE: tx_ready = RX FIFO not full; on handshake, latch byte and last flag, drive cs_n=0, go to CS_SETUP.
REQ-026 CS_SETUP: count CS_SETUP_CLKS cycles, then go to WRITE.
REQ-027 WRITE: exactly one cycle of spi_wr=1, spi_addr=SPDR_ADDR, spi_wdata=latched byte; then go to POLL.
REQ-028 POLL: spi_rd=1, spi_addr=SPSR_ADDR every cycle; if spi_rdata[7]=1, go to READ, otherwise stay in POLL; the SPI core clears SPIF on that read.
REQ-029 READ: one cycle of spi_rd=1, spi_addr=SPDR_ADDR; push spi_rdata into the RX FIFO; then go to NEXT.
REQ-030 NEXT: if the latched last flag is set, go to CS_HOLD; otherwise tx_ready = RX FIFO not full, and on handshake latch the byte and go directly to WRITE with cs_n held low; without a handshake, stay in NEXT.
REQ-031 CS_HOLD: count CS_HOLD_CLKS cycles with cs_n=0, then set cs_n=1 and go to IDLE.
REQ-032 tx_ready=0 in all states other than IDLE and NEXT.
REQ-033 spi_wr and spi_rd are never high in the same cycle; both are 0 outside WRITE, POLL and READ.
REQ-034 spi_addr=0 and spi_wdata=0 when no strobe is active.
REQ-035 Because a byte is accepted only when the RX FIFO has a free slot, the READ push never overflows.
REQ-036 Simultaneous push and pop on the RX FIFO: both succeed and the occupancy is unchanged; the FIFO pointers wrap modulo RX_FIFO_DEPTH.
REQ-037 RX FIFO head is combinational: rx_data is valid in the same cycle as rx_valid.

Reset
REQ-038 On rst: FSM=IDLE, cs_n=1, busy=0, tx_ready=0 during rst, spi_wr=0, spi_rd=0, spi_addr=0, spi_wdata=0, RX FIFO empty (rx_valid=0), counters=0.
REQ-039 rst mid-frame abandons the transfer immediately; cs_n=1 in the cycle after rst is sampled; no partial byte is pushed.

Structure
REQ-040 The FSM state encoding and the SPIF bit position (7) belong in the shared package atmega_spi_pkg.
REQ-041 The RX FIFO is the sub-module atmega_spi_burst_fifo (parameterised depth, synchronous push/pop, full/empty flags).

Verification
REQ-042 Loopback (miso=mosi), SPCR=0x50: single byte 0xA5 with last=1 -> one SPDR write, rx_data=0xA5, cs_n low for the whole transfer plus CS_SETUP_CLKS and CS_HOLD_CLKS cycles.
REQ-043 Frame 0x01,0x02,0x03 (last on 0x03) -> cs_n remains low between bytes; rx sequence 01,02,03; exactly 3 SPDR writes.
REQ-044 RX_FIFO_DEPTH=2, rx_ready=0, 4-byte frame -> after 2 bytes, tx_ready=0 and the FSM waits in NEXT with cs_n=0; raising rx_ready resumes the frame and all 4 bytes are received in order.
REQ-045 Slow prescaler (SPR=11) -> POLL repeats until SPIF; exactly one READ per byte; spi_wr/spi_rd never overlap.
REQ-046 rst asserted in POLL -> next cycle cs_n=1, busy=0, rx_valid=0; a new frame then completes normally.
REQ-047 Push and pop in the same cycle with FIFO full minus 1 -> occupancy unchanged, data order preserved across pointer wrap.
